// File: rtl/mmu_req_dispatch_if.sv
// Bundles the request-FIFO, core and reject channels of the MMU request dispatcher.
// master = the dispatcher, slave = the FIFOs and consumers around it.
interface mmu_req_dispatch_if #(
  parameter int unsigned ID_W   = 13,
  parameter int unsigned SIZE_W = 12,
  parameter int unsigned FR_W   = 2
);
  logic              alloc_fifo_not_empty;
  logic              alloc_fifo_pop;
  logic [ID_W-1:0]   alloc_fifo_id;
  logic [SIZE_W-1:0] alloc_fifo_page_count;

  logic              free_fifo_not_empty;
  logic              free_fifo_pop;
  logic [ID_W-1:0]   free_fifo_id;
  logic [SIZE_W-1:0] free_fifo_page_idx;
  logic [SIZE_W-1:0] free_fifo_page_count;

  logic              core_valid;
  logic              core_ready;
  logic              core_op;
  logic [ID_W-1:0]   core_id;
  logic [SIZE_W-1:0] core_page_idx;
  logic [1:0]        core_order;

  logic              rej_valid;
  logic              rej_ready;
  logic              rej_op;
  logic [ID_W-1:0]   rej_id;
  logic [FR_W-1:0]   rej_reason;

  modport master (
    input  alloc_fifo_not_empty, alloc_fifo_id, alloc_fifo_page_count,
    output alloc_fifo_pop,
    input  free_fifo_not_empty, free_fifo_id, free_fifo_page_idx, free_fifo_page_count,
    output free_fifo_pop,
    output core_valid, core_op, core_id, core_page_idx, core_order,
    input  core_ready,
    output rej_valid, rej_op, rej_id, rej_reason,
    input  rej_ready
  );

  modport slave (
    output alloc_fifo_not_empty, alloc_fifo_id, alloc_fifo_page_count,
    input  alloc_fifo_pop,
    output free_fifo_not_empty, free_fifo_id, free_fifo_page_idx, free_fifo_page_count,
    input  free_fifo_pop,
    input  core_valid, core_op, core_id, core_page_idx, core_order,
    output core_ready,
    input  rej_valid, rej_op, rej_id, rej_reason,
    output rej_ready
  );
endinterface

// File: rtl/mmu_req_dispatch.sv
// Round-robin dispatcher from the alloc/free request FIFOs to the allocator core.
// Normalises page count to an order and validates free requests; illegal ones go to the reject channel.
module mmu_req_dispatch #(
  parameter int unsigned ID_W     = 13,
  parameter int unsigned SIZE_W   = 12,
  parameter int unsigned FR_W     = 2,
  parameter int unsigned PAGE_NUM = 3276
) (
  input  logic              clk,
  input  logic              rst_n,
  mmu_req_dispatch_if.master bus
);

  localparam int unsigned SUM_W = SIZE_W + 1;

  localparam logic [FR_W-1:0] FR_NONE  = FR_W'(0);
  localparam logic [FR_W-1:0] FR_SIZE  = FR_W'(1);
  localparam logic [FR_W-1:0] FR_RANGE = FR_W'(2);
  localparam logic [FR_W-1:0] FR_ALIGN = FR_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_CHECK,
    S_ISSUE,
    S_REJECT
  } state_t;

  state_t state;
  logic   last_grant;   // 1 = free side served last
  logic   grant_free;

  logic              grant_c;
  logic              any_req_c;
  logic [ID_W-1:0]   sel_id_c;
  logic [SIZE_W-1:0] sel_idx_c;
  logic [SIZE_W-1:0] sel_count_c;
  logic [1:0]        chk_order_c;
  logic [SUM_W-1:0]  chk_span_c;
  logic [SUM_W-1:0]  chk_end_c;
  logic [SIZE_W-1:0] chk_mask_c;
  logic [FR_W-1:0]   chk_reason_c;

  // Arbitration: a tie goes to the side not served last time.
  always_comb begin
    any_req_c = bus.alloc_fifo_not_empty | bus.free_fifo_not_empty;
    if (bus.alloc_fifo_not_empty && bus.free_fifo_not_empty) begin
      grant_c = ~last_grant;
    end else begin
      grant_c = bus.free_fifo_not_empty;
    end
  end

  // Order normalisation and legality of the popped request.
  always_comb begin
    sel_id_c     = grant_free ? bus.free_fifo_id : bus.alloc_fifo_id;
    sel_idx_c    = grant_free ? bus.free_fifo_page_idx : '0;
    sel_count_c  = grant_free ? bus.free_fifo_page_count : bus.alloc_fifo_page_count;
    chk_order_c  = 2'd0;
    chk_reason_c = FR_NONE;

    if (sel_count_c == '0 || sel_count_c > SIZE_W'(8)) begin
      chk_reason_c = FR_SIZE;
    end else if (sel_count_c > SIZE_W'(4)) begin
      chk_order_c = 2'd3;
    end else if (sel_count_c > SIZE_W'(2)) begin
      chk_order_c = 2'd2;
    end else if (sel_count_c == SIZE_W'(2)) begin
      chk_order_c = 2'd1;
    end

    chk_span_c = SUM_W'(1) << chk_order_c;
    chk_end_c  = SUM_W'(sel_idx_c) + chk_span_c;
    chk_mask_c = SIZE_W'(chk_span_c - SUM_W'(1));

    if (chk_reason_c == FR_NONE && grant_free) begin
      if (SUM_W'(sel_idx_c) >= SUM_W'(PAGE_NUM)) begin
        chk_reason_c = FR_RANGE;
      end else if (chk_end_c > SUM_W'(PAGE_NUM)) begin
        chk_reason_c = FR_RANGE;
      end else if ((sel_idx_c & chk_mask_c) != '0) begin
        chk_reason_c = FR_ALIGN;
      end
    end
  end

  // Control FSM with registered pops and channel payloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      last_grant         <= 1'b1;
      grant_free         <= 1'b0;
      bus.alloc_fifo_pop <= 1'b0;
      bus.free_fifo_pop  <= 1'b0;
      bus.core_valid     <= 1'b0;
      bus.core_op        <= 1'b0;
      bus.core_id        <= '0;
      bus.core_page_idx  <= '0;
      bus.core_order     <= 2'd0;
      bus.rej_valid      <= 1'b0;
      bus.rej_op         <= 1'b0;
      bus.rej_id         <= '0;
      bus.rej_reason     <= FR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req_c) begin
            grant_free         <= grant_c;
            last_grant         <= grant_c;
            bus.alloc_fifo_pop <= ~grant_c;
            bus.free_fifo_pop  <= grant_c;
            state              <= S_POP;
          end
        end
        S_POP: begin
          bus.alloc_fifo_pop <= 1'b0;
          bus.free_fifo_pop  <= 1'b0;
          state              <= S_CHECK;
        end
        S_CHECK: begin
          if (chk_reason_c == FR_NONE) begin
            bus.core_valid    <= 1'b1;
            bus.core_op       <= grant_free;
            bus.core_id       <= sel_id_c;
            bus.core_page_idx <= sel_idx_c;
            bus.core_order    <= chk_order_c;
            state             <= S_ISSUE;
          end else begin
            bus.rej_valid  <= 1'b1;
            bus.rej_op     <= grant_free;
            bus.rej_id     <= sel_id_c;
            bus.rej_reason <= chk_reason_c;
            state          <= S_REJECT;
          end
        end
        S_ISSUE: begin
          if (bus.core_ready) begin
            bus.core_valid <= 1'b0;
            state          <= S_IDLE;
          end
        end
        S_REJECT: begin
          if (bus.rej_ready) begin
            bus.rej_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_req_dispatch.sv
// Self-checking bench for mmu_req_dispatch: FIFO model, request-level scoreboard and directed tests.
module tb_mmu_req_dispatch;
  localparam int unsigned ID_W   = 13;
  localparam int unsigned SIZE_W = 12;
  localparam int unsigned FR_W   = 2;
  localparam int          PAGES  = 3276;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mmu_req_dispatch_if #(.ID_W(ID_W), .SIZE_W(SIZE_W), .FR_W(FR_W)) bus ();

  mmu_req_dispatch #(.ID_W(ID_W), .SIZE_W(SIZE_W), .FR_W(FR_W), .PAGE_NUM(32'(PAGES))) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int id;
    int idx;
    int cnt;
  } req_t;

  typedef struct {
    bit rej;
    bit op;
    int id;
    int idx;
    int order;
    int reason;
  } exp_t;

  req_t aq[$];
  req_t fq[$];
  exp_t expq[$];
  int   glog[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mlast = 1'b1;
  int n_core = 0, n_rej = 0, cv_cnt = 0;
  int pop_cyc = -1, cv_cyc = -1;
  int lc_op, lc_id, lc_idx, lc_order;
  int lr_op, lr_id, lr_reason;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Request-level reference: smallest power of two covering the count, then range/alignment rules.
  function automatic exp_t model(input bit f, input int id, input int idx, input int cnt);
    exp_t e;
    int   sz;
    e.rej = 1'b0; e.op = f; e.id = id; e.idx = f ? idx : 0; e.order = 0; e.reason = 0;
    if (cnt < 1 || cnt > 8) begin
      e.rej = 1'b1; e.reason = 1;
    end else begin
      sz = 1;
      while (sz < cnt) begin
        sz = sz * 2;
        e.order++;
      end
      if (f) begin
        if (idx >= PAGES || idx + sz > PAGES) begin
          e.rej = 1'b1; e.reason = 2;
        end else if (idx % sz != 0) begin
          e.rej = 1'b1; e.reason = 3;
        end
      end
    end
    return e;
  endfunction

  task automatic push_a(input int id, input int cnt);
    req_t r;
    r.id = id; r.idx = 0; r.cnt = cnt;
    aq.push_back(r);
    bus.alloc_fifo_not_empty = 1'b1;
  endtask

  task automatic push_f(input int id, input int idx, input int cnt);
    req_t r;
    r.id = id; r.idx = idx; r.cnt = cnt;
    fq.push_back(r);
    bus.free_fifo_not_empty = 1'b1;
  endtask

  // FIFO model plus per-cycle compare against the scoreboard.
  initial begin : mon
    logic        pcv, pcr, prv, prr;
    logic [28:0] pcore;
    logic [16:0] prej;
    logic [28:0] ncore;
    logic [16:0] nrej;
    req_t        r;
    exp_t        e;
    bit          side, es;
    pcv = 0; pcr = 0; prv = 0; prr = 0; pcore = '0; prej = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        expq.delete();
        mlast = 1'b1;
        pcv = 0; prv = 0;
        chk("reset_outputs", 32'({bus.alloc_fifo_pop, bus.free_fifo_pop, bus.core_valid, bus.rej_valid}), 0);
        continue;
      end
      ncore = {bus.core_valid, bus.core_op, bus.core_id, bus.core_page_idx, bus.core_order};
      nrej  = {bus.rej_valid, bus.rej_op, bus.rej_id, bus.rej_reason};
      chk("valid_exclusive", 32'(bus.core_valid & bus.rej_valid), 0);
      chk("pop_exclusive", 32'(bus.alloc_fifo_pop & bus.free_fifo_pop), 0);
      if (pcv && !pcr) chk("core_hold", 32'(ncore), 32'(pcore));
      if (prv && !prr) chk("rej_hold", 32'(nrej), 32'(prej));

      if (bus.alloc_fifo_pop || bus.free_fifo_pop) begin
        side = bus.free_fifo_pop;
        es = (aq.size() > 0 && fq.size() > 0) ? !mlast : (fq.size() > 0);
        chk("grant_side", 32'(side), 32'(es));
        if (pop_cyc < 0) pop_cyc = cyc;
        if ((side && fq.size() == 0) || (!side && aq.size() == 0)) begin
          chk("pop_of_empty_fifo", 1, 0);
        end else begin
          mlast = side;
          glog.push_back(int'(side));
          if (side) begin
            r = fq.pop_front();
            bus.free_fifo_id         = ID_W'(r.id);
            bus.free_fifo_page_idx   = SIZE_W'(r.idx);
            bus.free_fifo_page_count = SIZE_W'(r.cnt);
          end else begin
            r = aq.pop_front();
            bus.alloc_fifo_id         = ID_W'(r.id);
            bus.alloc_fifo_page_count = SIZE_W'(r.cnt);
          end
          expq.push_back(model(side, r.id, r.idx, r.cnt));
          bus.alloc_fifo_not_empty = (aq.size() != 0);
          bus.free_fifo_not_empty  = (fq.size() != 0);
        end
      end

      if (bus.core_valid) begin
        cv_cnt++;
        if (cv_cyc < 0) cv_cyc = cyc;
      end
      if (bus.core_valid && bus.core_ready) begin
        if (expq.size() == 0) chk("core_unexpected", 1, 0);
        else begin
          e = expq.pop_front();
          chk("core_kind_rej", 32'(e.rej), 0);
          chk("core_op", 32'(bus.core_op), 32'(e.op));
          chk("core_id", 32'(bus.core_id), 32'(e.id));
          chk("core_page_idx", 32'(bus.core_page_idx), 32'(e.idx));
          chk("core_order", 32'(bus.core_order), 32'(e.order));
        end
        n_core++;
        lc_op = int'(bus.core_op); lc_id = int'(bus.core_id);
        lc_idx = int'(bus.core_page_idx); lc_order = int'(bus.core_order);
      end
      if (bus.rej_valid && bus.rej_ready) begin
        if (expq.size() == 0) chk("rej_unexpected", 1, 0);
        else begin
          e = expq.pop_front();
          chk("rej_kind_rej", 32'(e.rej), 1);
          chk("rej_op", 32'(bus.rej_op), 32'(e.op));
          chk("rej_id", 32'(bus.rej_id), 32'(e.id));
          chk("rej_reason", 32'(bus.rej_reason), 32'(e.reason));
        end
        n_rej++;
        lr_op = int'(bus.rej_op); lr_id = int'(bus.rej_id); lr_reason = int'(bus.rej_reason);
      end
      pcv = bus.core_valid; pcr = bus.core_ready; pcore = ncore;
      prv = bus.rej_valid;  prr = bus.rej_ready;  prej  = nrej;
    end
  end

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (aq.size() == 0 && fq.size() == 0 && expq.size() == 0 &&
          !bus.core_valid && !bus.rej_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_core_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (bus.core_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 1);
  endtask

  initial begin : main
    int t0, n0, c0;
    rst_n = 1'b0;
    bus.core_ready = 1'b1;
    bus.rej_ready  = 1'b1;
    bus.alloc_fifo_not_empty = 1'b0;
    bus.free_fifo_not_empty  = 1'b0;
    bus.alloc_fifo_id = '0; bus.alloc_fifo_page_count = '0;
    bus.free_fifo_id = '0; bus.free_fifo_page_idx = '0; bus.free_fifo_page_count = '0;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_core_valid", 32'(bus.core_valid), 0);
    chk("rst_rej_valid", 32'(bus.rej_valid), 0);
    chk("rst_pops", 32'({bus.alloc_fifo_pop, bus.free_fifo_pop}), 0);
    chk("rst_core_id", 32'(bus.core_id), 0);
    chk("rst_rej_reason", 32'(bus.rej_reason), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single alloc: latency and payload.
    pop_cyc = -1; cv_cyc = -1; t0 = cyc; c0 = cv_cnt;
    push_a(5, 3);
    wait_idle("t1_done");
    chk("t1_pop_latency", 32'(pop_cyc - t0), 1);
    chk("t1_valid_latency", 32'(cv_cyc - t0), 3);
    chk("t1_valid_cycles", 32'(cv_cnt - c0), 1);
    chk("t1_op", 32'(lc_op), 0);
    chk("t1_id", 32'(lc_id), 5);
    chk("t1_order", 32'(lc_order), 2);
    chk("t1_idx", 32'(lc_idx), 0);

    // Alloc size rejects.
    n0 = n_core;
    push_a(11, 0);
    wait_idle("t2a_done");
    chk("t2a_op", 32'(lr_op), 0); chk("t2a_id", 32'(lr_id), 11); chk("t2a_reason", 32'(lr_reason), 1);
    push_a(12, 9);
    wait_idle("t2b_done");
    chk("t2b_op", 32'(lr_op), 0); chk("t2b_id", 32'(lr_id), 12); chk("t2b_reason", 32'(lr_reason), 1);
    chk("t2_no_core", 32'(n_core - n0), 0);

    // Free legality.
    push_f(7, 16, 8);
    wait_idle("t3a_done");
    chk("t3a_op", 32'(lc_op), 1); chk("t3a_id", 32'(lc_id), 7);
    chk("t3a_idx", 32'(lc_idx), 16); chk("t3a_order", 32'(lc_order), 3);
    push_f(8, 12, 8);
    wait_idle("t3b_done");
    chk("t3b_op", 32'(lr_op), 1); chk("t3b_reason", 32'(lr_reason), 3);
    push_f(9, 3272, 8);
    wait_idle("t3c_done");
    chk("t3c_id", 32'(lr_id), 9); chk("t3c_reason", 32'(lr_reason), 2);
    push_f(10, 3276, 1);
    wait_idle("t3d_done");
    chk("t3d_id", 32'(lr_id), 10); chk("t3d_reason", 32'(lr_reason), 2);

    // Round robin with both FIFOs loaded.
    glog.delete();
    push_a(40, 1); push_a(41, 2); push_a(42, 4);
    push_f(50, 0, 4); push_f(51, 4, 4); push_f(52, 8, 8);
    wait_idle("t4_done");
    chk("t4_grants", 32'(glog.size()), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("t4_grant_order", 32'(glog[i]), 32'(i % 2));

    // Core backpressure.
    bus.core_ready = 1'b0;
    glog.delete();
    push_a(20, 2); push_a(21, 1);
    wait_core_valid("t5_valid_seen");
    repeat (10) @(negedge clk);
    #2;
    chk("t5_still_valid", 32'(bus.core_valid), 1);
    chk("t5_id_held", 32'(bus.core_id), 20);
    chk("t5_order_held", 32'(bus.core_order), 1);
    chk("t5_no_extra_pop", 32'(glog.size()), 1);
    @(negedge clk);
    n0 = n_core;
    bus.core_ready = 1'b1;
    wait_idle("t5_done");
    chk("t5_accepts", 32'(n_core - n0), 2);
    chk("t5_last_id", 32'(lc_id), 21);

    // Reset during ISSUE.
    bus.core_ready = 1'b0;
    glog.delete();
    push_a(30, 1); push_a(31, 1); push_f(32, 0, 1); push_f(33, 8, 1);
    wait_core_valid("t6_valid_seen");
    chk("t6_first_grant_free", 32'(glog.size() > 0 ? glog[0] : -1), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_drop", 32'(bus.core_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    glog.delete();
    #2;
    chk("t6_no_pop_after_release", 32'({bus.alloc_fifo_pop, bus.free_fifo_pop}), 0);
    bus.core_ready = 1'b1;
    wait_idle("t6_done");
    chk("t6_grants", 32'(glog.size()), 3);
    if (glog.size() == 3) begin
      chk("t6_g0_alloc", 32'(glog[0]), 0);
      chk("t6_g1_free", 32'(glog[1]), 1);
      chk("t6_g2_alloc", 32'(glog[2]), 0);
    end
    chk("t6_last_id", 32'(lc_id), 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
